// File: rtl/xdata_src_pkg.sv
// rtl/xdata_src_pkg.sv - shared types and config sizing for xdata_src (XDATA_SRC_DUTY_EN adds duty field)
package xdata_src_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Total configdata width; the duty field only exists when the macro is set.
  function automatic int conf_bits(input int data_w, input int iter_w,
                                   input int per_w, input int delay_w);
`ifdef XDATA_SRC_DUTY_EN
    return 3*data_w + iter_w + 2*per_w + delay_w;
`else
    return 3*data_w + iter_w + per_w + delay_w;
`endif
  endfunction

endpackage

// File: rtl/xdata_src_cnt.sv
// rtl/xdata_src_cnt.sv - nested outer/inner loop counter with period-end and last-iteration flags
module xdata_src_cnt #(
  parameter int ITER_W = 10,
  parameter int PER_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [ITER_W-1:0] iter,
  input  logic [PER_W-1:0]  per,
  output logic [PER_W-1:0]  j,
  output logic              last_per,
  output logic              last_iter
);

  logic [ITER_W-1:0] i;

  assign last_per  = (j == per - PER_W'(1));
  assign last_iter = (i == iter - ITER_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      j <= '0;
      i <= '0;
    end else if (en) begin
      if (last_per) begin
        j <= '0;
        i <= last_iter ? '0 : i + ITER_W'(1);
      end else begin
        j <= j + PER_W'(1);
      end
    end
  end

endmodule

// File: rtl/xdata_src.sv
// rtl/xdata_src.sv - Versat data-bus source emitting a two-level loop sequence (XDATA_SRC_DUTY_EN adds duty field)
module xdata_src
  import xdata_src_pkg::*;
#(
  parameter int  DATA_W    = 32,
  parameter int  ITER_W    = 10,
  parameter int  PER_W     = 10,
  parameter int  DELAY_W   = 5,
  localparam int CONF_BITS = conf_bits(DATA_W, ITER_W, PER_W, DELAY_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [CONF_BITS-1:0] configdata,
  output logic [DATA_W-1:0]    flow_out,
  output logic                 busy,
  output logic                 done
);

  localparam int DUTY_BITS = CONF_BITS - (3*DATA_W + ITER_W + PER_W + DELAY_W);
  localparam int DELAY_LSB = DUTY_BITS;
  localparam int PER_LSB   = DELAY_LSB + DELAY_W;
  localparam int ITER_LSB  = PER_LSB + PER_W;
  localparam int SHIFT_LSB = ITER_LSB + ITER_W;
  localparam int INCR_LSB  = SHIFT_LSB + DATA_W;
  localparam int START_LSB = INCR_LSB + DATA_W;

  state_t state, state_nx;

  logic [DATA_W-1:0]  start_r, incr_r, shift_r;
  logic [ITER_W-1:0]  iter_r;
  logic [PER_W-1:0]   per_r;
  logic [DELAY_W-1:0] delay_r, dcnt;
  logic [PER_W-1:0]   duty_eff;
  logic [PER_W-1:0]   j;
  logic               last_per, last_iter, accept, adv;

  logic [ITER_W-1:0]  cfg_iter;
  logic [PER_W-1:0]   cfg_per;
  logic [DELAY_W-1:0] cfg_delay;

  assign cfg_iter  = configdata[ITER_LSB +: ITER_W];
  assign cfg_per   = configdata[PER_LSB +: PER_W];
  assign cfg_delay = configdata[DELAY_LSB +: DELAY_W];

  assign accept = run && (state == S_IDLE || state == S_DONE);
  assign busy   = (state == S_DELAY) || (state == S_RUN);
  assign done   = (state == S_DONE);

`ifdef XDATA_SRC_DUTY_EN
  logic [PER_W-1:0] duty_r;
  assign duty_eff = duty_r;
`else
  assign duty_eff = '1;
`endif

  // The word after position j moves by incr only if that next position is still inside the duty window.
  assign adv = ({1'b0, j} + (PER_W+1)'(1)) < {1'b0, duty_eff};

  xdata_src_cnt #(.ITER_W(ITER_W), .PER_W(PER_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .en        (state == S_RUN),
    .iter      (iter_r),
    .per       (per_r),
    .j         (j),
    .last_per  (last_per),
    .last_iter (last_iter)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (run) begin
          if (cfg_iter == '0 || cfg_per == '0) state_nx = S_DONE;
          else if (cfg_delay != '0)            state_nx = S_DELAY;
          else                                 state_nx = S_RUN;
        end
      end
      S_DELAY: if (dcnt == delay_r - DELAY_W'(1)) state_nx = S_RUN;
      S_RUN:   if (last_per && last_iter) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flow_out <= '0;
      start_r  <= '0;
      incr_r   <= '0;
      shift_r  <= '0;
      iter_r   <= '0;
      per_r    <= '0;
      delay_r  <= '0;
      dcnt     <= '0;
`ifdef XDATA_SRC_DUTY_EN
      duty_r   <= '0;
`endif
    end else if (accept) begin
      start_r  <= configdata[START_LSB +: DATA_W];
      incr_r   <= configdata[INCR_LSB +: DATA_W];
      shift_r  <= configdata[SHIFT_LSB +: DATA_W];
      iter_r   <= cfg_iter;
      per_r    <= cfg_per;
      delay_r  <= cfg_delay;
      dcnt     <= '0;
      flow_out <= configdata[START_LSB +: DATA_W];
`ifdef XDATA_SRC_DUTY_EN
      duty_r   <= configdata[PER_W-1:0];
`endif
    end else if (state == S_DELAY) begin
      dcnt <= dcnt + DELAY_W'(1);
    end else if (state == S_RUN) begin
      if (last_per) flow_out <= flow_out + shift_r;
      else if (adv) flow_out <= flow_out + incr_r;
    end
  end

endmodule

// File: tb/tb_xdata_src.sv
// tb/tb_xdata_src.sv - self-checking bench for xdata_src against a closed-form sequence model
module tb_xdata_src;
  import xdata_src_pkg::*;

  localparam int DATA_W    = 32;
  localparam int ITER_W    = 10;
  localparam int PER_W     = 10;
  localparam int DELAY_W   = 5;
  localparam int CONF_BITS = conf_bits(DATA_W, ITER_W, PER_W, DELAY_W);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 run;
  logic [CONF_BITS-1:0] configdata;
  logic [DATA_W-1:0]    flow_out;
  logic                 busy;
  logic                 done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xdata_src #(
    .DATA_W  (DATA_W),
    .ITER_W  (ITER_W),
    .PER_W   (PER_W),
    .DELAY_W (DELAY_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .configdata (configdata),
    .flow_out   (flow_out),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [CONF_BITS-1:0] pack(input logic [31:0] st, input logic [31:0] inc,
                                                input logic [31:0] sh, input int it, input int pe,
                                                input int dl, input int du);
    logic [ITER_W-1:0]  f_it;
    logic [PER_W-1:0]   f_pe;
    logic [DELAY_W-1:0] f_dl;
    logic [PER_W-1:0]   f_du;
    f_it = ITER_W'(it);
    f_pe = PER_W'(pe);
    f_dl = DELAY_W'(dl);
    f_du = PER_W'(du);
`ifdef XDATA_SRC_DUTY_EN
    return {st, inc, sh, f_it, f_pe, f_dl, f_du};
`else
    return {st, inc, sh, f_it, f_pe, f_dl} | CONF_BITS'(f_du & '0);
`endif
  endfunction

  // Word (i,j): each full period contributes (incr steps inside the duty window) plus one shift.
  function automatic logic [31:0] exp_word(input logic [31:0] st, input logic [31:0] inc,
                                           input logic [31:0] sh, input int pe, input int du,
                                           input int i, input int j);
    int de, nin, jj;
    de = (du < pe) ? du : pe;
`ifndef XDATA_SRC_DUTY_EN
    de = pe;
`endif
    nin = (de > 0) ? de - 1 : 0;
    jj  = (j < nin) ? j : nin;
    return st + 32'(i) * (32'(nin) * inc + sh) + 32'(jj) * inc;
  endfunction

  task automatic run_seq(input logic [31:0] st, input logic [31:0] inc, input logic [31:0] sh,
                         input int it, input int pe, input int dl, input int du, input bit poke);
    int n;
    n = it * pe;
    @(negedge clk);
    configdata = pack(st, inc, sh, it, pe, dl, du);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    configdata = pack($urandom, $urandom, $urandom, $urandom_range(1, 7), $urandom_range(1, 7),
                      $urandom_range(0, 3), $urandom_range(0, 7));
    if (it == 0 || pe == 0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_flow", flow_out, st);
    end else begin
      check("start_done_clr", done, 0);
      for (int d = 0; d < dl; d++) begin
        check("delay_flow", flow_out, st);
        check("delay_busy", busy, 1);
        @(negedge clk);
      end
      for (int k = 0; k < n; k++) begin
        check("run_flow", flow_out, exp_word(st, inc, sh, pe, du, k / pe, k % pe));
        check("run_busy", busy, 1);
        check("run_done", done, 0);
        run = (poke && k == 1);
        @(negedge clk);
      end
      run = 1'b0;
      check("end_done", done, 1);
      check("end_busy", busy, 0);
      check("end_flow", flow_out, exp_word(st, inc, sh, pe, du, it, 0));
    end
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    configdata = '0;
    repeat (2) @(negedge clk);
    check("rst_flow", flow_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    run_seq(32'd25, 32'd1, 32'd10, 2, 3, 0, 1023, 1'b0);
    run_seq(32'd25, 32'd1, 32'd10, 2, 3, 4, 1023, 1'b1);
    run_seq(32'hFFFF_FFFE, 32'd1, 32'd0, 1, 4, 0, 1023, 1'b0);
    run_seq(32'd77, 32'd3, 32'd9, 0, 5, 2, 1023, 1'b0);
    run_seq(32'd78, 32'd3, 32'd9, 3, 0, 0, 1023, 1'b0);
    run_seq(32'd5, 32'd3, 32'hFFFF_FFFE, 4, 1, 1, 1023, 1'b0);
    run_seq(32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 3, 3, 0, 1023, 1'b1);

    // Abort mid-run; run asserted with the reset must lose.
    @(negedge clk);
    configdata = pack(32'd100, 32'd3, 32'd50, 3, 3, 0, 1023);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    @(negedge clk);
    check("abort_flow", flow_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    run = 1'b0;
    run_seq(32'd100, 32'd3, 32'd50, 3, 3, 0, 1023, 1'b0);

`ifdef XDATA_SRC_DUTY_EN
    run_seq(32'd0, 32'd2, 32'd100, 2, 4, 0, 2, 1'b0);
    run_seq(32'd7, 32'd5, 32'd1, 2, 3, 1, 0, 1'b0);
`endif

    for (int r = 0; r < 8; r++) begin
      run_seq($urandom, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(1, 4),
              $urandom_range(0, 3), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
